wb_unit: RTL and testbench

Parametrised, registered writeback stage for the 16-bit pipelined processor. It replaces the purely combinational writeback path with a MEM/WB pipeline register, and adds a result-source select (ALU / memory / link) and byte/word load extraction with sign or zero extension. It also supports variable-latency data-memory responses, using a stall handshake toward MEM and a timeout abort. It drives the register-file write port in ID and exposes a retired-instruction counter.

---
 rtl/wb_unit.sv | 160 ++++++++++++++++
 tb/tb_wb_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// wb_unit: registered MEM/WB writeback stage with result-source select,
// byte/word load extraction and a variable-latency memory wait with timeout.
module wb_unit #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned REG_WIDTH   = 4,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned ZERO_REG_EN = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   validM_i,
  input  logic [DATA_WIDTH-1:0]  WBResultM_i,
  input  logic [ADDR_WIDTH-1:0]  PCPlus1M_i,
  input  logic [REG_WIDTH-1:0]   WriteRegM_i,
  input  logic                   RegWriteM_i,
  input  logic [1:0]             ResultSrcM_i,
  input  logic                   LoadByteM_i,
  input  logic                   LoadSignedM_i,
  input  logic                   ByteSelM_i,
  input  logic                   memRspValid_i,
  input  logic [DATA_WIDTH-1:0]  memData_r_i,
  output logic                   stallW_o,
  output logic                   RegWriteW_o,
  output logic [REG_WIDTH-1:0]   WriteRegW_o,
  output logic [DATA_WIDTH-1:0]  ResultW_o,
  output logic                   memTimeout_o,
  output logic [COUNT_WIDTH-1:0] retiredCount_o
);

  // Timeout counter only needs to hold 0 .. MEM_TIMEOUT-1.
  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [REG_WIDTH-1:0]   ld_reg_q, ld_reg_d;
  logic                   ld_rw_q, ld_rw_d;
  logic                   ld_byte_q, ld_byte_d;
  logic                   ld_signed_q, ld_signed_d;
  logic                   ld_sel_q, ld_sel_d;
  logic                   we_q, we_d;
  logic [REG_WIDTH-1:0]   wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0]  res_q, res_d;
  logic                   to_q, to_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [7:0]            byte_v;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  blk_m, blk_ld;

  // Load data extraction and register-0 write suppression.
  always_comb begin
    byte_v  = ld_sel_q ? memData_r_i[15:8] : memData_r_i[7:0];
    ld_data = memData_r_i;
    if (ld_byte_q) begin
      ld_data = {{(DATA_WIDTH-8){ld_signed_q & byte_v[7]}}, byte_v};
    end
    blk_m  = (ZERO_REG_EN != 0) && (WriteRegM_i == '0);
    blk_ld = (ZERO_REG_EN != 0) && (ld_reg_q == '0);
  end

  // Next-state and writeback register update.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    ld_reg_d    = ld_reg_q;
    ld_rw_d     = ld_rw_q;
    ld_byte_d   = ld_byte_q;
    ld_signed_d = ld_signed_q;
    ld_sel_d    = ld_sel_q;
    we_d        = 1'b0;
    wreg_d      = wreg_q;
    res_d       = res_q;
    to_d        = to_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (validM_i) begin
          if (ResultSrcM_i == 2'b01) begin
            ld_reg_d    = WriteRegM_i;
            ld_rw_d     = RegWriteM_i;
            ld_byte_d   = LoadByteM_i;
            ld_signed_d = LoadSignedM_i;
            ld_sel_d    = ByteSelM_i;
            tcnt_d      = '0;
            state_d     = WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (RegWriteM_i && !blk_m) begin
              we_d   = 1'b1;
              wreg_d = WriteRegM_i;
              res_d  = (ResultSrcM_i == 2'b10) ? DATA_WIDTH'(PCPlus1M_i) : WBResultM_i;
            end
          end
        end
      end
      WAIT: begin
        // A response on the timeout edge takes priority over the abort.
        if (memRspValid_i) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 1'b1;
          if (ld_rw_q && !blk_ld) begin
            we_d   = 1'b1;
            wreg_d = ld_reg_q;
            res_d  = ld_data;
          end
        end else if (tcnt_q == TMAX) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      ld_reg_q    <= '0;
      ld_rw_q     <= 1'b0;
      ld_byte_q   <= 1'b0;
      ld_signed_q <= 1'b0;
      ld_sel_q    <= 1'b0;
      we_q        <= 1'b0;
      wreg_q      <= '0;
      res_q       <= '0;
      to_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      ld_reg_q    <= ld_reg_d;
      ld_rw_q     <= ld_rw_d;
      ld_byte_q   <= ld_byte_d;
      ld_signed_q <= ld_signed_d;
      ld_sel_q    <= ld_sel_d;
      we_q        <= we_d;
      wreg_q      <= wreg_d;
      res_q       <= res_d;
      to_q        <= to_d;
      cnt_q       <= cnt_d;
    end
  end

  assign stallW_o       = (state_q == WAIT);
  assign RegWriteW_o    = we_q;
  assign WriteRegW_o    = wreg_q;
  assign ResultW_o      = res_q;
  assign memTimeout_o   = to_q;
  assign retiredCount_o = cnt_q;

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed scenarios plus random traffic, checked against
// a transaction-level model of the writeback behaviour.
module tb_wb_unit;
  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        valid = 1'b0, rw = 1'b0, lb = 1'b0, ls = 1'b0, bs = 1'b0, rsp = 1'b0;
  logic [15:0] alu = '0, mdata = '0;
  logic [7:0]  pc = '0;
  logic [3:0]  wr = '0;
  logic [1:0]  src = '0;
  logic        stall, we, tout;
  logic [3:0]  wreg;
  logic [15:0] res, cnt;

  wb_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .REG_WIDTH(4), .COUNT_WIDTH(16),
            .MEM_TIMEOUT(TO), .ZERO_REG_EN(1)) dut (
    .clk(clk), .rst(rst), .validM_i(valid), .WBResultM_i(alu), .PCPlus1M_i(pc),
    .WriteRegM_i(wr), .RegWriteM_i(rw), .ResultSrcM_i(src), .LoadByteM_i(lb),
    .LoadSignedM_i(ls), .ByteSelM_i(bs), .memRspValid_i(rsp), .memData_r_i(mdata),
    .stallW_o(stall), .RegWriteW_o(we), .WriteRegW_o(wreg), .ResultW_o(res),
    .memTimeout_o(tout), .retiredCount_o(cnt));

  int n_assert = 0;
  int n_fail   = 0;

  // Model: one pending load at most, tracked by its age in cycles.
  bit          m_busy, m_rw, m_b, m_s, m_sel;
  int          m_age;
  logic [3:0]  m_reg;
  bit          e_we, e_to;
  logic [3:0]  e_reg;
  logic [15:0] e_res, e_cnt;

  function automatic logic [15:0] extract(input logic [15:0] d, input bit isbyte,
                                          input bit sg, input bit sel);
    int v;
    if (!isbyte) return d;
    v = sel ? (int'(d) >> 8) : int'(d);
    v = v % 256;
    if (sg && v >= 128) v = v + 'hFF00;
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0; e_we = 0; e_to = 0; e_reg = '0; e_res = '0; e_cnt = '0;
  endtask

  task automatic model_edge();
    e_we = 0;
    if (m_busy) begin
      m_age++;
      if (rsp) begin
        m_busy = 0;
        e_cnt++;
        if (m_rw && m_reg != 0) begin
          e_we = 1; e_reg = m_reg; e_res = extract(mdata, m_b, m_s, m_sel);
        end
      end else if (m_age == TO) begin
        m_busy = 0;
        e_to = 1;
      end
    end else if (valid) begin
      if (src == 2'b01) begin
        m_busy = 1; m_age = 0; m_reg = wr; m_rw = rw; m_b = lb; m_s = ls; m_sel = bs;
      end else begin
        e_cnt++;
        if (rw && wr != 0) begin
          e_we = 1; e_reg = wr; e_res = (src == 2'b10) ? {8'h00, pc} : alu;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("stall", 32'(stall), 32'(m_busy));
    check("we", 32'(we), 32'(e_we));
    check("wreg", 32'(wreg), 32'(e_reg));
    check("res", 32'(res), 32'(e_res));
    check("timeout", 32'(tout), 32'(e_to));
    check("count", 32'(cnt), 32'(e_cnt));
  endtask

  task automatic step(input bit chk);
    @(posedge clk);
    model_edge();
    #1;
    if (chk) check_all();
    valid = 0; rsp = 0;
  endtask

  task automatic op(input logic [1:0] s, input logic [3:0] r, input logic w,
                    input logic [15:0] a, input logic [7:0] p,
                    input logic b, input logic sg, input logic sel);
    valid = 1; src = s; wr = r; rw = w; alu = a; pc = p; lb = b; ls = sg; bs = sel;
  endtask

  task automatic resp(input logic [15:0] d);
    rsp = 1; mdata = d;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 0);
    check({tag, "_we"}, 32'(we), 0);
    check({tag, "_wreg"}, 32'(wreg), 0);
    check({tag, "_res"}, 32'(res), 0);
    check({tag, "_to"}, 32'(tout), 0);
    check({tag, "_cnt"}, 32'(cnt), 0);
  endtask

  initial begin
    model_reset();
    #12;
    check_zero("reset");
    rst = 1;

    // ALU op R3 <- 0x1234
    op(2'b00, 4'd3, 1, 16'h1234, 8'h00, 0, 0, 0);
    step(1);
    check("alu_we", 32'(we), 1);
    check("alu_reg", 32'(wreg), 3);
    check("alu_res", 32'(res), 32'h1234);
    check("alu_cnt", 32'(cnt), 1);
    step(1);
    check("alu_pulse_end", 32'(we), 0);

    // Word load to R5, response three cycles after accept
    op(2'b01, 4'd5, 1, 16'h0, 8'h0, 0, 0, 0);
    step(1);
    step(1);
    step(1);
    check("lw_stall", 32'(stall), 1);
    resp(16'hBEEF);
    step(1);
    check("lw_res", 32'(res), 32'hBEEF);
    check("lw_we", 32'(we), 1);
    check("lw_cnt", 32'(cnt), 2);

    // Byte loads, minimum latency
    op(2'b01, 4'd6, 1, 16'h0, 8'h0, 1, 1, 1); step(1);
    resp(16'h80FF); step(1);
    check("lbs_hi", 32'(res), 32'hFF80);
    op(2'b01, 4'd7, 1, 16'h0, 8'h0, 1, 0, 0); step(1);
    resp(16'h80FF); step(1);
    check("lbu_lo", 32'(res), 32'h00FF);
    op(2'b01, 4'd8, 1, 16'h0, 8'h0, 1, 1, 0); step(1);
    resp(16'h127F); step(1);
    check("lbs_lo", 32'(res), 32'h007F);

    // Timeout: abort on the 15th edge after accept
    op(2'b01, 4'd9, 1, 16'h0, 8'h0, 0, 0, 0); step(1);
    for (int i = 1; i < TO; i++) step(1);
    check("to_pre_stall", 32'(stall), 1);
    step(1);
    check("to_flag", 32'(tout), 1);
    check("to_stall", 32'(stall), 0);
    check("to_cnt", 32'(cnt), 5);
    resp(16'h5555); step(1);
    check("late_rsp_we", 32'(we), 0);

    // Link op to R15, then suppressed write to R0
    op(2'b10, 4'd15, 1, 16'hFFFF, 8'hA5, 0, 0, 0); step(1);
    check("link_res", 32'(res), 32'h00A5);
    op(2'b00, 4'd0, 1, 16'h7777, 8'h00, 0, 0, 0); step(1);
    check("r0_we", 32'(we), 0);
    check("r0_cnt", 32'(cnt), 7);

    // Random traffic: fast then slow memory
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0)
        op(2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom), 16'($urandom),
           8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else
        valid = 0;
      mdata = 16'($urandom);
      rsp = ($urandom_range(0, 99) < ((i < 300) ? 40 : 4));
      step(1);
    end

    // Drain any pending load, then drive the counter to wrap
    for (int i = 0; i < 2 * TO && m_busy; i++) step(1);
    check("drain", 32'(stall), 0);
    while (e_cnt != 16'hFFFF) begin
      op(2'b00, 4'd1, 0, 16'h0, 8'h0, 0, 0, 0);
      step(0);
    end
    check_all();
    check("cnt_ffff", 32'(cnt), 32'hFFFF);
    op(2'b00, 4'd2, 1, 16'h4242, 8'h0, 0, 0, 0); step(1);
    check("cnt_wrap", 32'(cnt), 0);

    // Reset in the middle of a wait
    op(2'b01, 4'd4, 1, 16'h0, 8'h0, 0, 0, 0); step(1);
    step(1);
    check("rst_wait_stall", 32'(stall), 1);
    #2 rst = 0;
    #1 model_reset();
    check_zero("rst_mid");
    #3 rst = 1;
    resp(16'hDEAD); step(1);
    check("post_rst_we", 32'(we), 0);
    check("post_rst_res", 32'(res), 0);
    check("post_rst_cnt", 32'(cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
